// File: rtl/mm_exp_ctrl.sv
// rtl/mm_exp_ctrl.sv - left-to-right binary exponentiation sequencer for a Montgomery multiplier
module mm_exp_ctrl #(
    parameter int EXP_AW     = 8,
    parameter int MM_TIMEOUT = 4096
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [EXP_AW-1:0] exp_len,
    output logic [EXP_AW-1:0] exp_bit_addr,
    input  logic              exp_bit,
    output logic              mm_start,
    input  logic              mm_done,
    output logic [2:0]        mm_opa_sel,
    output logic [2:0]        mm_opb_sel,
    output logic              mm_dst_sel,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [15:0]       op_count
);

    localparam int TW = $clog2(MM_TIMEOUT + 1);
    localparam logic [TW-1:0]     T_LAST = TW'(MM_TIMEOUT - 1);
    localparam logic [TW-1:0]     T_ONE  = TW'(1);
    localparam logic [EXP_AW-1:0] I_ONE  = EXP_AW'(1);

    localparam logic [2:0] SRC_ACC = 3'd0;
    localparam logic [2:0] SRC_XM  = 3'd1;
    localparam logic [2:0] SRC_X   = 3'd2;
    localparam logic [2:0] SRC_R2  = 3'd3;
    localparam logic [2:0] SRC_ONE = 3'd4;

    typedef enum logic [3:0] {
        S_IDLE, S_INIT_X, S_INIT_A, S_FETCH, S_BIT,
        S_SQR, S_MUL, S_FIN, S_WAIT, S_DONE
    } state_t;

    state_t            state, state_nx;
    state_t            src, src_nx;
    state_t            op_state;
    logic [EXP_AW-1:0] idx, idx_nx;
    logic              bit_q, bit_nx;
    logic              err_q, err_nx;
    logic [15:0]       op_cnt;
    logic [TW-1:0]     wcnt;
    logic              issue;
    logic              accept;
    logic              step;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state  <= S_IDLE;
            src    <= S_IDLE;
            idx    <= '0;
            bit_q  <= 1'b0;
            err_q  <= 1'b0;
            op_cnt <= 16'd0;
            wcnt   <= '0;
        end else begin
            state <= state_nx;
            src   <= src_nx;
            idx   <= idx_nx;
            bit_q <= bit_nx;
            err_q <= err_nx;
            if (accept)
                op_cnt <= 16'd0;
            else if (issue && op_cnt != 16'hFFFF)
                op_cnt <= op_cnt + 16'd1;
            // wcnt counts the issue cycle too, so timeout lands MM_TIMEOUT cycles after mm_start
            if (issue)
                wcnt <= T_ONE;
            else if (state == S_WAIT)
                wcnt <= wcnt + T_ONE;
        end
    end

    always_comb begin
        state_nx = state;
        src_nx   = src;
        idx_nx   = idx;
        bit_nx   = bit_q;
        err_nx   = 1'b0;
        issue    = 1'b0;
        accept   = 1'b0;
        step     = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    if (exp_len != '0) begin
                        accept   = 1'b1;
                        idx_nx   = exp_len - I_ONE;
                        state_nx = S_INIT_X;
                    end else begin
                        err_nx = 1'b1;
                    end
                end
            end
            S_INIT_X, S_INIT_A, S_SQR, S_MUL, S_FIN: begin
                issue    = 1'b1;
                src_nx   = state;
                state_nx = S_WAIT;
            end
            S_FETCH: state_nx = S_BIT;
            S_BIT: begin
                bit_nx   = exp_bit;
                state_nx = S_SQR;
            end
            S_WAIT: begin
                if (mm_done) begin
                    case (src)
                        S_INIT_X: state_nx = S_INIT_A;
                        S_INIT_A: state_nx = S_FETCH;
                        S_SQR: begin
                            if (bit_q) state_nx = S_MUL;
                            else       step     = 1'b1;
                        end
                        S_MUL:   step     = 1'b1;
                        S_FIN:   state_nx = S_DONE;
                        default: state_nx = S_IDLE;
                    endcase
                    if (step) begin
                        if (idx != '0) begin
                            idx_nx   = idx - I_ONE;
                            state_nx = S_FETCH;
                        end else begin
                            state_nx = S_FIN;
                        end
                    end
                end else if (wcnt >= T_LAST) begin
                    err_nx   = 1'b1;
                    state_nx = S_IDLE;
                end
            end
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // Selects follow the issuing op from its mm_start cycle until WAIT is left.
    always_comb begin
        op_state   = issue ? state : ((state == S_WAIT) ? src : S_IDLE);
        mm_opa_sel = SRC_ACC;
        mm_opb_sel = SRC_ACC;
        mm_dst_sel = 1'b0;
        case (op_state)
            S_INIT_X: begin mm_opa_sel = SRC_X;   mm_opb_sel = SRC_R2;  mm_dst_sel = 1'b1; end
            S_INIT_A: begin mm_opa_sel = SRC_ONE; mm_opb_sel = SRC_R2;  end
            S_MUL:    begin mm_opa_sel = SRC_ACC; mm_opb_sel = SRC_XM;  end
            S_FIN:    begin mm_opa_sel = SRC_ACC; mm_opb_sel = SRC_ONE; end
            default:  begin mm_opa_sel = SRC_ACC; mm_opb_sel = SRC_ACC; end
        endcase
    end

    assign mm_start     = issue;
    assign busy         = (state != S_IDLE) && (state != S_DONE);
    assign done         = (state == S_DONE);
    assign err          = err_q;
    assign op_count     = op_cnt;
    assign exp_bit_addr = idx;

endmodule

// File: tb/tb_mm_exp_ctrl.sv
// tb/tb_mm_exp_ctrl.sv - self-checking bench for mm_exp_ctrl against a multiply-sequence model
module tb_mm_exp_ctrl;

    localparam int AW  = 8;
    localparam int TMO = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] exp_len = '0;
    logic [AW-1:0] exp_bit_addr;
    logic          exp_bit;
    logic          mm_start;
    logic          mm_done = 1'b0;
    logic [2:0]    opa, opb;
    logic          dst;
    logic          busy, done, err;
    logic [15:0]   op_count;

    logic       exp_mem [0:255];
    logic [6:0] obs_q[$];
    logic [6:0] exp_q[$];

    int n_assert = 0;
    int n_fail   = 0;
    int r_done, r_err, r_sel_bad, r_first_start, r_err_cyc;

    mm_exp_ctrl #(.EXP_AW(AW), .MM_TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst), .start(start), .exp_len(exp_len),
        .exp_bit_addr(exp_bit_addr), .exp_bit(exp_bit),
        .mm_start(mm_start), .mm_done(mm_done),
        .mm_opa_sel(opa), .mm_opb_sel(opb), .mm_dst_sel(dst),
        .busy(busy), .done(done), .err(err), .op_count(op_count)
    );

    always #5 clk = ~clk;

    // Exponent bit RAM with one cycle of read latency
    always @(posedge clk) exp_bit <= exp_mem[exp_bit_addr];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_done"}, 32'(done), 0);
        chk({tag, "_err"}, 32'(err), 0);
        chk({tag, "_mm_start"}, 32'(mm_start), 0);
        chk({tag, "_op_count"}, 32'(op_count), 0);
        chk({tag, "_addr"}, 32'(exp_bit_addr), 0);
        chk({tag, "_sels"}, 32'({opa, opb, dst}), 0);
    endtask

    // Left-to-right square-and-multiply: the operation list implied by the exponent
    task automatic build_model(input int len);
        exp_q.delete();
        exp_q.push_back({3'd2, 3'd3, 1'b1});
        exp_q.push_back({3'd4, 3'd3, 1'b0});
        for (int i = len - 1; i >= 0; i--) begin
            exp_q.push_back({3'd0, 3'd0, 1'b0});
            if (exp_mem[i]) exp_q.push_back({3'd0, 3'd1, 1'b0});
        end
        exp_q.push_back({3'd0, 3'd4, 1'b0});
    endtask

    task automatic run_exp(input int len, input int delay, input bit spam, input bit stray);
        int         t;
        bit         pending;
        logic [6:0] hold;
        int         tail;
        obs_q.delete();
        r_done = 0; r_err = 0; r_sel_bad = 0; r_first_start = -1; r_err_cyc = -1;
        pending = 0; t = 0; tail = -1; hold = '0;
        @(negedge clk);
        exp_len = AW'(len);
        start   = 1'b1;
        for (int cyc = 0; cyc < 20000; cyc++) begin
            @(negedge clk);
            start   = spam;
            mm_done = 1'b0;
            if (mm_start) begin
                obs_q.push_back({opa, opb, dst});
                hold    = {opa, opb, dst};
                pending = 1;
                t       = delay;
                if (r_first_start < 0) r_first_start = cyc;
            end else if (pending) begin
                if ({opa, opb, dst} !== hold) r_sel_bad++;
                if (delay != 0) begin
                    t--;
                    if (t == 0) begin
                        mm_done = 1'b1;
                        pending = 0;
                    end
                end
            end else if (stray && busy && $urandom_range(2) == 0) begin
                mm_done = 1'b1;
            end
            if (done) r_done++;
            if (err) begin
                r_err++;
                if (r_err_cyc < 0) r_err_cyc = cyc;
            end
            if ((done || err) && tail < 0) tail = 4;
            if (tail >= 0) begin
                start = 1'b0;
                if (tail == 0) break;
                tail--;
            end
        end
        start   = 1'b0;
        mm_done = 1'b0;
        chk("run_finished_in_budget", 32'(tail == 0), 1);
    endtask

    task automatic verify(input int len, input string tag);
        int pop;
        build_model(len);
        pop = 0;
        for (int i = 0; i < len; i++) pop += int'(exp_mem[i]);
        chk({tag, "_n_ops"}, 32'(obs_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++)
            chk($sformatf("%s_op%0d", tag, i), 32'(obs_q[i]), 32'(exp_q[i]));
        chk({tag, "_op_count"}, 32'(op_count), 32'(3 + len + pop));
        chk({tag, "_done_pulses"}, 32'(r_done), 1);
        chk({tag, "_err_pulses"}, 32'(r_err), 0);
        chk({tag, "_sel_stable"}, 32'(r_sel_bad), 0);
        chk({tag, "_busy_after"}, 32'(busy), 0);
    endtask

    initial begin
        int len, bad, nst, tt;
        for (int i = 0; i < 256; i++) exp_mem[i] = 1'b0;

        repeat (3) @(negedge clk);
        chk_reset("reset");
        rst = 1'b1;
        @(negedge clk);

        // exponent 101b, multiplier answers 5 cycles after each launch
        exp_mem[2] = 1'b1; exp_mem[1] = 1'b0; exp_mem[0] = 1'b1;
        run_exp(3, 5, 0, 0);
        verify(3, "e101");
        chk("e101_op_count_8", 32'(op_count), 8);

        // zero-length exponent: err next cycle, nothing launched
        @(negedge clk);
        exp_len = '0;
        start   = 1'b1;
        chk("len0_err_before", 32'(err), 0);
        @(negedge clk);
        start = 1'b0;
        chk("len0_err_pulse", 32'(err), 1);
        chk("len0_busy", 32'(busy), 0);
        bad = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (mm_start || busy || err) bad++;
        end
        chk("len0_quiet", 32'(bad), 0);

        // multiplier never answers: timeout abort
        run_exp(2, 0, 0, 0);
        chk("tmo_err_pulses", 32'(r_err), 1);
        chk("tmo_latency", 32'(r_err_cyc - r_first_start), TMO);
        chk("tmo_done_pulses", 32'(r_done), 0);
        chk("tmo_busy", 32'(busy), 0);
        chk("tmo_op_count", 32'(op_count), 1);

        // start hammered during a run is ignored
        exp_mem[1] = 1'b1; exp_mem[0] = 1'b1;
        run_exp(2, 3, 1, 0);
        verify(2, "spam");
        chk("spam_op_count_7", 32'(op_count), 7);

        // random exponents with stray mm_done outside WAIT
        for (int r = 0; r < 6; r++) begin
            len = $urandom_range(20, 1);
            for (int i = 0; i < len; i++) exp_mem[i] = 1'($urandom_range(1));
            run_exp(len, $urandom_range(6, 1), r[0], 1);
            verify(len, $sformatf("rnd%0d", r));
        end

        // reset during the first squaring's WAIT, then a late mm_done
        exp_mem[3] = 1'b1; exp_mem[2] = 1'b0;
        @(negedge clk);
        exp_len = AW'(4);
        start   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        nst = 0; tt = -1;
        for (int k = 0; k < 200; k++) begin
            mm_done = 1'b0;
            if (mm_start) begin
                nst++;
                tt = 5;
            end else if (tt > 0) begin
                tt--;
                if (tt == 0) mm_done = 1'b1;
            end
            if (nst == 3) break;
            @(negedge clk);
        end
        chk("rst_reached_sqr", 32'(nst), 3);
        mm_done = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_in_wait_busy", 32'(busy), 1);
        rst = 1'b0;
        @(negedge clk);
        chk_reset("midwait_reset");
        rst = 1'b1;
        @(negedge clk);
        mm_done = 1'b1;
        @(negedge clk);
        mm_done = 1'b0;
        bad = 0;
        for (int k = 0; k < 10; k++) begin
            if (mm_start || done || busy || err) bad++;
            @(negedge clk);
        end
        chk("late_done_ignored", 32'(bad), 0);
        chk_reset("after_late_done");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/mm_exp_ctrl.md
MM_EXP_CTRL -- requirements
Module: mm_exp_ctrl

Interface
REQ-001 Parameter: EXP_AW, 8, exponent bit-address width; max exponent length 2^EXP_AW-1.
REQ-002 Parameter: MM_TIMEOUT, 4096, max cycles from mm_start to mm_done before abort.
REQ-003 clk  in  1  clock; all state updates on rising edge.
REQ-004 rst  in  1  reset, synchronous, active-low.
REQ-005 start  in  1  one-cycle request to begin an exponentiation.
REQ-006 exp_len  in  EXP_AW  number of exponent bits, sampled on accepted start.
REQ-007 exp_bit_addr  out  EXP_AW  exponent bit-RAM read address.
REQ-008 exp_bit  in  1  exponent bit read data, valid one cycle after exp_bit_addr.
REQ-009 mm_start  out  1  one-cycle pulse launching one Montgomery multiply.
REQ-010 mm_done  in  1  one-cycle pulse from multiplier: result written.
REQ-011 mm_opa_sel  out  3  operand A source: 0 ACC, 1 XM, 2 X, 3 R2, 4 ONE.
REQ-012 mm_opb_sel  out  3  operand B source, same encoding.
REQ-013 mm_dst_sel  out  1  result destination: 0 ACC, 1 XM.
REQ-014 busy  out  1  high from accepted start until done/err.
REQ-015 done  out  1  one-cycle pulse: ACC holds X^E in normal domain.
REQ-016 err  out  1  one-cycle pulse: exp_len==0 or timeout.
REQ-017 op_count  out  16  multiplies issued since last accepted start.

Function
REQ-018 States SHALL be: IDLE, INIT_X, INIT_A, FETCH, BIT, SQR, MUL, FIN, WAIT, DONE.
REQ-019 IDLE: start=1, exp_len!=0 -> INIT_X, busy=1, op_count=0, bit index i=exp_len-1; start=1, exp_len==0 -> err pulse next cycle, stay IDLE, no mm_start.
REQ-020 INIT_X SHALL issue XM = X*R2 (opa=2, opb=3, dst=1); INIT_A SHALL issue ACC = ONE*R2 (opa=4, opb=3, dst=0).
REQ-021 FETCH SHALL drive exp_bit_addr=i; BIT SHALL sample exp_bit, store it, go to SQR.
REQ-022 SQR SHALL issue ACC = ACC*ACC (opa=0, opb=0, dst=0).
REQ-023 After SQR completes: stored bit=1 -> MUL issuing ACC = ACC*XM (opa=0, opb=1, dst=0); bit=0 -> next-bit step.
REQ-024 Next-bit step: i>0 -> i=i-1, FETCH; i==0 -> FIN.
REQ-025 FIN SHALL issue ACC = ACC*ONE (opa=0, opb=4, dst=0); on completion -> DONE.
REQ-026 Every issue state SHALL assert mm_start for exactly one cycle, increment op_count (saturating at 0xFFFF), then enter WAIT.
REQ-027 mm_opa_sel/mm_opb_sel/mm_dst_sel SHALL be valid in the mm_start cycle and held stable until the cycle mm_done is sampled.
REQ-028 WAIT SHALL return to the successor of the issuing state on the cycle after mm_done=1; mm_done outside WAIT is ignored.
REQ-029 WAIT cycle counter SHALL clear on mm_start; reaching MM_TIMEOUT without mm_done -> err pulse, busy=0, IDLE.
REQ-030 DONE SHALL pulse done for one cycle, drop busy same cycle, return to IDLE.
REQ-031 start while busy=1 SHALL be ignored; op_count SHALL hold its value after done/err until next accepted start.
REQ-032 Multiply count for a run SHALL be 3 + exp_len + popcount(exponent bits).

Reset
REQ-033 rst=0 at a clock edge SHALL force IDLE, busy=0, done=0, err=0, mm_start=0, op_count=0, exp_bit_addr=0, all selects=0, counters=0, in any state including mid-WAIT.
REQ-034 mm_done arriving after a mid-operation reset SHALL be ignored.

Verification
REQ-035 exp_len=3, bits[2:0]=101, mm_done 5 cycles after each mm_start -> sequence INIT_X, INIT_A, SQR, MUL, SQR, SQR, MUL, FIN; op_count=8; one done pulse.
REQ-036 exp_len=0, start=1 -> err pulse one cycle later; no mm_start; busy stays 0.
REQ-037 MM_TIMEOUT=16, mm_done never asserted -> err pulse 16 cycles after first mm_start; busy=0; IDLE.
REQ-038 rst=0 during WAIT of SQR, late mm_done after release -> all outputs at reset values; no mm_start, no done.
REQ-039 start pulsed every cycle during exp_len=2, bits=11 run -> op_count=7 exactly, single done pulse.
REQ-040 Stray mm_done in FETCH/BIT -> ignored; selects remain stable through each WAIT.
